// File: rtl/ntt_perm_pkg.sv
// Shared types and index math for the NTT stride / bit-reverse
// frame permutation.
package ntt_perm_pkg;

   localparam int unsigned DEF_W      = 28;
   localparam int unsigned DEF_P      = 32;
   localparam int unsigned DEF_N      = 1024;
   localparam int unsigned DEF_P_LOG2 = $clog2(DEF_P);

   typedef enum logic {
      PERM_STRIDE = 1'b0,
      PERM_BITREV = 1'b1
   } perm_mode_e;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_FILL = 1'b1
   } wr_state_e;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_DRAIN = 1'b1
   } rd_state_e;

   // Source position of output index k; n and s are powers of two.
   function automatic int unsigned src_index(
      input int unsigned k,
      input int unsigned n,
      input int unsigned s,
      input perm_mode_e  mode
   );
      int unsigned r;
      int unsigned t;
      r = 0;
      t = k;
      if (mode == PERM_BITREV) begin
         for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
               r = (r << 1) | (t & 32'd1);
               t = t >> 1;
            end
         end
      end else begin
         r = (k % s) * (n / s) + k / s;
      end
      return r;
   endfunction

endpackage

// File: rtl/perm_index_gen.sv
// Combinational source-address generator: one bank address per lane
// for a given output beat.
module perm_index_gen
   import ntt_perm_pkg::*;
#(
   parameter int unsigned N    = DEF_N,
   parameter int unsigned P    = DEF_P,
   parameter int unsigned S    = 1,
   parameter perm_mode_e  MODE = PERM_STRIDE
) (
   input  logic [$clog2(N/P)-1:0]   beat,
   output logic [P*$clog2(N)-1:0]   addr
);

   localparam int unsigned AW = $clog2(N);

   always_comb begin
      addr = '0;
      for (int unsigned l = 0; l < P; l++) begin
         addr[l*AW +: AW] =
            AW'(src_index(32'(beat) * P + l, N, S, MODE));
      end
   end

endmodule

// File: rtl/stride_permutation_stream.sv
// Ping-pong frame buffer that streams NTT frames out in stride or
// bit-reversed order at full rate.
module stride_permutation_stream
   import ntt_perm_pkg::*;
#(
   parameter int DATA_WIDTH_PER_INPUT = DEF_W,
   parameter int INPUT_PER_CYCLE      = DEF_P,
   parameter int NUM_POINTS           = DEF_N,
   parameter int STRIDE_LOG2          = DEF_P_LOG2,
   parameter int MODE                 = 0
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_valid,
   input  logic                                          in_start,
   input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] in_data,
   output logic                                          out_valid,
   output logic                                          out_start,
   output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] out_data,
   output logic                                          drop_pulse
);

   localparam int W  = DATA_WIDTH_PER_INPUT;
   localparam int P  = INPUT_PER_CYCLE;
   localparam int N  = NUM_POINTS;
   localparam int B  = N / P;
   localparam int AW = $clog2(N);
   localparam int BW = $clog2(B);
   localparam int unsigned S = 32'd1 << STRIDE_LOG2;
   localparam perm_mode_e PMODE = perm_mode_e'(MODE[0]);

   logic [W-1:0]    mem [2*N];
   wr_state_e       wr_state, wr_next;
   rd_state_e       rd_state, rd_next;
   logic            wr_bank, rd_bank;
   logic [BW-1:0]   wr_beat, rd_beat, w_beat, r_beat;
   logic [1:0]      full, full_next;
   logic            do_write, drop, frame_done, emit, last;
   logic [P*AW-1:0] rd_addr;
   logic [P*W-1:0]  rd_data;

   always_comb begin
      wr_next    = wr_state;
      do_write   = 1'b0;
      drop       = 1'b0;
      w_beat     = wr_beat;
      frame_done = 1'b0;
      unique case (wr_state)
         WR_IDLE: begin
            if (in_valid && in_start) begin
               do_write = 1'b1;
               w_beat   = '0;
               wr_next  = WR_FILL;
            end
         end
         WR_FILL: begin
            if (in_valid) begin
               do_write = 1'b1;
               // A restart reuses the same bank from beat 0.
               if (in_start) begin
                  drop   = 1'b1;
                  w_beat = '0;
               end
            end
         end
         default: ;
      endcase
      frame_done = do_write && (w_beat == BW'(B - 1));
      if (frame_done) wr_next = WR_IDLE;
   end

   always_comb begin
      rd_next   = rd_state;
      emit      = full[rd_bank];
      r_beat    = (rd_state == RD_DRAIN) ? rd_beat : '0;
      last      = emit && (r_beat == BW'(B - 1));
      full_next = full;
      unique case (rd_state)
         RD_IDLE:  if (emit) rd_next = RD_DRAIN;
         RD_DRAIN: if (last) rd_next = RD_IDLE;
         default: ;
      endcase
      if (last)       full_next[rd_bank] = 1'b0;
      if (frame_done) full_next[wr_bank] = 1'b1;
   end

   perm_index_gen #(
      .N    (N),
      .P    (P),
      .S    (S),
      .MODE (PMODE)
   ) u_index (
      .beat (r_beat),
      .addr (rd_addr)
   );

   always_comb begin
      rd_data = '0;
      for (int l = 0; l < P; l++) begin
         rd_data[l*W +: W] = mem[{rd_bank, rd_addr[l*AW +: AW]}];
      end
   end

   always_ff @(posedge clk) begin
      if (do_write && !rst) begin
         for (int l = 0; l < P; l++) begin
            mem[{wr_bank, AW'(int'(w_beat) * P + l)}] <= in_data[l*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state   <= WR_IDLE;
         rd_state   <= RD_IDLE;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wr_beat    <= '0;
         rd_beat    <= '0;
         full       <= '0;
         out_valid  <= 1'b0;
         out_start  <= 1'b0;
         out_data   <= '0;
         drop_pulse <= 1'b0;
      end else begin
         wr_state   <= wr_next;
         rd_state   <= rd_next;
         full       <= full_next;
         if (do_write)   wr_beat <= w_beat + 1'b1;
         if (frame_done) wr_bank <= ~wr_bank;
         rd_beat    <= emit ? r_beat + 1'b1 : '0;
         if (last)       rd_bank <= ~rd_bank;
         out_valid  <= emit;
         out_start  <= emit && (rd_state == RD_IDLE);
         out_data   <= emit ? rd_data : '0;
         drop_pulse <= drop;
      end
   end

endmodule
